ysyx_23060236_writeback: RTL and testbench

//  Writeback stage (WBU) of the RV32E core; sits directly upstream of the register file.

---
 rtl/ysyx_23060236_writeback_pkg.sv | 19 +
 rtl/ysyx_23060236_writeback_if.sv | 41 ++++
 rtl/ysyx_23060236_load_ext.sv | 26 ++
 rtl/ysyx_23060236_writeback.sv | 122 ++++++++++++
 tb/tb_ysyx_23060236_writeback.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060236_writeback_pkg.sv
// rtl/ysyx_23060236_writeback_pkg.sv - shared widths, load funct3 codes, response codes and WBU states
package ysyx_23060236_writeback_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } wb_state_e;
endpackage

// File: rtl/ysyx_23060236_writeback_if.sv
// rtl/ysyx_23060236_writeback_if.sv - EXU/LSU/regfile/bypass signal bundle of the writeback stage
interface ysyx_23060236_writeback_if;
  import ysyx_23060236_writeback_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_wen;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic [1:0]            in_addr_lo;
  logic [DATA_WIDTH-1:0] in_exu_data;
  logic [DATA_WIDTH-1:0] in_pc;
  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            mem_rresp;
  logic                  rf_valid;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  fwd_busy;
  logic [ADDR_WIDTH-1:0] fwd_rd;
  logic                  fwd_data_ok;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  load_fault;

  modport master (
    input  in_valid, in_wen, in_rd, in_is_load, in_funct3, in_addr_lo, in_exu_data, in_pc,
    input  mem_rvalid, mem_rdata, mem_rresp,
    output in_ready, mem_rready, rf_valid, rf_wen, rf_waddr, rf_wdata,
    output fwd_busy, fwd_rd, fwd_data_ok, fwd_data, load_fault
  );

  modport slave (
    output in_valid, in_wen, in_rd, in_is_load, in_funct3, in_addr_lo, in_exu_data, in_pc,
    output mem_rvalid, mem_rdata, mem_rresp,
    input  in_ready, mem_rready, rf_valid, rf_wen, rf_waddr, rf_wdata,
    input  fwd_busy, fwd_rd, fwd_data_ok, fwd_data, load_fault
  );
endinterface

// File: rtl/ysyx_23060236_load_ext.sv
// rtl/ysyx_23060236_load_ext.sv - selects and sign/zero-extends load data from a word-aligned read
module ysyx_23060236_load_ext
  import ysyx_23060236_writeback_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] result
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result   = '0;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LW:   result = rdata;
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/ysyx_23060236_writeback.sv
// rtl/ysyx_23060236_writeback.sv - RV32E writeback stage driving the regfile write port and bypass view
// YSYX_23060236_WB_COMMIT_EN adds commit_valid/commit_pc/commit_count trace outputs.
module ysyx_23060236_writeback
  import ysyx_23060236_writeback_pkg::*;
(
  input  logic clock,
  input  logic reset,
  ysyx_23060236_writeback_if.master bus
`ifdef YSYX_23060236_WB_COMMIT_EN
  ,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic [63:0]           commit_count
`endif
);
  wb_state_e             state, state_nx;
  logic                  ent_wen;
  logic [ADDR_WIDTH-1:0] ent_rd;
  logic [DATA_WIDTH-1:0] ent_data;
  logic [2:0]            ent_funct3;
  logic [1:0]            ent_addr_lo;
  logic                  ent_fault;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  accept, mem_hs, mem_ok, rd_nz, busy;

  ysyx_23060236_load_ext u_load_ext (
    .funct3  (ent_funct3),
    .addr_lo (ent_addr_lo),
    .rdata   (bus.mem_rdata),
    .result  (ext_data)
  );

  // in_ready is held low while reset is asserted so every output reads 0 during reset
  assign bus.in_ready   = !reset && (state != S_WAIT_MEM);
  assign bus.mem_rready = (state == S_WAIT_MEM);
  assign accept         = bus.in_valid && bus.in_ready;
  assign mem_hs         = bus.mem_rvalid && bus.mem_rready;
  assign mem_ok         = (bus.mem_rresp == RESP_OKAY);
  assign rd_nz          = (ent_rd != '0);
  assign busy           = (state != S_IDLE) && ent_wen && rd_nz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_WRITE: begin
        if (accept) state_nx = bus.in_is_load ? S_WAIT_MEM : S_WRITE;
        else        state_nx = S_IDLE;
      end
      S_WAIT_MEM: if (mem_hs) state_nx = S_WRITE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_wen     <= 1'b0;
      ent_rd      <= '0;
      ent_data    <= '0;
      ent_funct3  <= '0;
      ent_addr_lo <= '0;
      ent_fault   <= 1'b0;
    end else if (accept) begin
      ent_wen     <= bus.in_wen;
      ent_rd      <= bus.in_rd;
      ent_data    <= bus.in_is_load ? '0 : bus.in_exu_data;
      ent_funct3  <= bus.in_funct3;
      ent_addr_lo <= bus.in_addr_lo;
      ent_fault   <= 1'b0;
    end else if (mem_hs) begin
      // an error response retires the load without touching the register file
      ent_data    <= mem_ok ? ext_data : '0;
      ent_wen     <= ent_wen && mem_ok;
      ent_fault   <= !mem_ok;
    end
  end

  always_comb begin
    bus.rf_valid    = 1'b0;
    bus.rf_wen      = 1'b0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    bus.load_fault  = 1'b0;
    bus.fwd_busy    = busy;
    bus.fwd_rd      = '0;
    bus.fwd_data_ok = 1'b0;
    bus.fwd_data    = '0;
    if (state == S_WRITE) begin
      bus.rf_valid   = 1'b1;
      bus.rf_wen     = ent_wen && rd_nz;
      bus.rf_waddr   = ent_rd;
      bus.rf_wdata   = ent_data;
      bus.load_fault = ent_fault;
    end
    if (busy) begin
      bus.fwd_rd      = ent_rd;
      bus.fwd_data_ok = (state == S_WRITE);
      bus.fwd_data    = ent_data;
    end
  end

`ifdef YSYX_23060236_WB_COMMIT_EN
  logic [DATA_WIDTH-1:0] ent_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_pc       <= '0;
      commit_count <= '0;
    end else begin
      if (accept)            ent_pc       <= bus.in_pc;
      if (state == S_WRITE)  commit_count <= commit_count + 64'd1;
    end
  end

  assign commit_valid = (state == S_WRITE);
  assign commit_pc    = (state == S_WRITE) ? ent_pc : '0;
`endif
endmodule

// File: tb/tb_ysyx_23060236_writeback.sv
// tb/tb_ysyx_23060236_writeback.sv - directed vector bench for the writeback stage
module tb_ysyx_23060236_writeback;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ysyx_23060236_writeback_if bus ();

  ysyx_23060236_writeback dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] exu;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic        chk_wdata;
    logic [31:0] exp_wdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_wen      = 1'b0;
    bus.in_rd       = '0;
    bus.in_is_load  = 1'b0;
    bus.in_funct3   = '0;
    bus.in_addr_lo  = '0;
    bus.in_exu_data = '0;
    bus.in_pc       = '0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rresp   = '0;
  endtask

  task automatic offer(input logic is_load, input logic [2:0] f3, input logic [1:0] alo,
                       input logic wen, input logic [4:0] rd, input logic [31:0] exu);
    bus.in_valid    = 1'b1;
    bus.in_is_load  = is_load;
    bus.in_funct3   = f3;
    bus.in_addr_lo  = alo;
    bus.in_wen      = wen;
    bus.in_rd       = rd;
    bus.in_exu_data = exu;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 2'd0, 32'h0,         2'b00, 1'b1, 5'd5,  32'h0000_1234, 1'b1, 5'd5,  1'b1, 32'h0000_1234, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 2'd0, 32'h0,         2'b00, 1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 5'd0,  1'b1, 32'h0000_DEAD, 1'b0};
    vecs[2]  = '{1'b1, 3'b000, 2'd3, 32'h80FF_0000, 2'b00, 1'b1, 5'd8,  32'h0,         1'b1, 5'd8,  1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[3]  = '{1'b1, 3'b101, 2'd2, 32'h80FF_0000, 2'b00, 1'b1, 5'd8,  32'h0,         1'b1, 5'd8,  1'b1, 32'h0000_80FF, 1'b0};
    vecs[4]  = '{1'b1, 3'b001, 2'd2, 32'h80FF_0000, 2'b00, 1'b1, 5'd6,  32'h0,         1'b1, 5'd6,  1'b1, 32'hFFFF_80FF, 1'b0};
    vecs[5]  = '{1'b1, 3'b100, 2'd1, 32'h1234_5678, 2'b00, 1'b1, 5'd11, 32'h0,         1'b1, 5'd11, 1'b1, 32'h0000_0056, 1'b0};
    vecs[6]  = '{1'b1, 3'b010, 2'd2, 32'h89AB_CDEF, 2'b00, 1'b1, 5'd15, 32'h0,         1'b1, 5'd15, 1'b1, 32'h89AB_CDEF, 1'b0};
    vecs[7]  = '{1'b1, 3'b000, 2'd0, 32'h1234_5678, 2'b00, 1'b1, 5'd2,  32'h0,         1'b1, 5'd2,  1'b1, 32'h0000_0078, 1'b0};
    vecs[8]  = '{1'b1, 3'b011, 2'd0, 32'h1234_5678, 2'b00, 1'b1, 5'd9,  32'h0,         1'b1, 5'd9,  1'b1, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 3'b010, 2'd0, 32'h1234_5678, 2'b10, 1'b1, 5'd10, 32'h0,         1'b0, 5'd10, 1'b0, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 3'b001, 2'd0, 32'h0000_7FFF, 2'b00, 1'b1, 5'd3,  32'h0,         1'b1, 5'd3,  1'b1, 32'h0000_7FFF, 1'b0};
    vecs[11] = '{1'b0, 3'b000, 2'd0, 32'h0,         2'b00, 1'b0, 5'd4,  32'hCAFE_F00D, 1'b0, 5'd4,  1'b1, 32'hCAFE_F00D, 1'b0};

    idle_inputs();
    reset = 1'b1;
    #1;
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("reset rf_valid", {31'd0, bus.rf_valid}, 32'd0);
    check("reset fwd_busy", {31'd0, bus.fwd_busy}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("idle in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("idle mem_rready", {31'd0, bus.mem_rready}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      offer(vecs[i].is_load, vecs[i].funct3, vecs[i].addr_lo, vecs[i].wen, vecs[i].rd, vecs[i].exu);
      @(negedge clock);
      idle_inputs();
      if (vecs[i].is_load) begin
        check($sformatf("v%0d mem_rready", i), {31'd0, bus.mem_rready}, 32'd1);
        check($sformatf("v%0d rf_valid wait", i), {31'd0, bus.rf_valid}, 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = vecs[i].rdata;
        bus.mem_rresp  = vecs[i].rresp;
        @(negedge clock);
        idle_inputs();
      end
      check($sformatf("v%0d rf_valid", i), {31'd0, bus.rf_valid}, 32'd1);
      check($sformatf("v%0d rf_wen", i), {31'd0, bus.rf_wen}, {31'd0, vecs[i].exp_wen});
      check($sformatf("v%0d rf_waddr", i), {27'd0, bus.rf_waddr}, {27'd0, vecs[i].exp_waddr});
      if (vecs[i].chk_wdata)
        check($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d load_fault", i), {31'd0, bus.load_fault}, {31'd0, vecs[i].exp_fault});
      @(negedge clock);
      check($sformatf("v%0d rf_valid after", i), {31'd0, bus.rf_valid}, 32'd0);
      check($sformatf("v%0d load_fault after", i), {31'd0, bus.load_fault}, 32'd0);
    end

    // three back-to-back ALU ops
    @(negedge clock);
    offer(1'b0, 3'b000, 2'd0, 1'b1, 5'd1, 32'h0000_0011);
    check("b2b ready0", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clock);
    check("b2b ready1", {31'd0, bus.in_ready}, 32'd1);
    check("b2b valid1", {31'd0, bus.rf_valid}, 32'd1);
    check("b2b waddr1", {27'd0, bus.rf_waddr}, 32'd1);
    offer(1'b0, 3'b000, 2'd0, 1'b1, 5'd2, 32'h0000_0022);
    @(negedge clock);
    check("b2b ready2", {31'd0, bus.in_ready}, 32'd1);
    check("b2b valid2", {31'd0, bus.rf_valid}, 32'd1);
    check("b2b waddr2", {27'd0, bus.rf_waddr}, 32'd2);
    check("b2b wdata2", bus.rf_wdata, 32'h0000_0022);
    offer(1'b0, 3'b000, 2'd0, 1'b1, 5'd3, 32'h0000_0033);
    @(negedge clock);
    idle_inputs();
    check("b2b valid3", {31'd0, bus.rf_valid}, 32'd1);
    check("b2b waddr3", {27'd0, bus.rf_waddr}, 32'd3);
    check("b2b wdata3", bus.rf_wdata, 32'h0000_0033);
    @(negedge clock);
    check("b2b valid end", {31'd0, bus.rf_valid}, 32'd0);

    // load rd=7 with delayed memory response; extra in_valid must be ignored
    offer(1'b1, 3'b010, 2'd0, 1'b1, 5'd7, 32'h0);
    @(negedge clock);
    offer(1'b0, 3'b000, 2'd0, 1'b1, 5'd9, 32'h0000_0999);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("wait%0d fwd_busy", c), {31'd0, bus.fwd_busy}, 32'd1);
      check($sformatf("wait%0d fwd_rd", c), {27'd0, bus.fwd_rd}, 32'd7);
      check($sformatf("wait%0d fwd_data_ok", c), {31'd0, bus.fwd_data_ok}, 32'd0);
      check($sformatf("wait%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
      check($sformatf("wait%0d rf_valid", c), {31'd0, bus.rf_valid}, 32'd0);
      @(negedge clock);
    end
    idle_inputs();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122_3344;
    @(negedge clock);
    idle_inputs();
    check("dly rf_valid", {31'd0, bus.rf_valid}, 32'd1);
    check("dly rf_waddr", {27'd0, bus.rf_waddr}, 32'd7);
    check("dly rf_wdata", bus.rf_wdata, 32'h1122_3344);
    check("dly fwd_data_ok", {31'd0, bus.fwd_data_ok}, 32'd1);
    check("dly fwd_data", bus.fwd_data, 32'h1122_3344);
    @(negedge clock);
    check("dly fwd_busy end", {31'd0, bus.fwd_busy}, 32'd0);
    check("dly rf_valid end", {31'd0, bus.rf_valid}, 32'd0);

    // reset during WAIT_MEM abandons the load
    offer(1'b1, 3'b010, 2'd0, 1'b1, 5'd12, 32'h0);
    @(negedge clock);
    idle_inputs();
    check("rst pre mem_rready", {31'd0, bus.mem_rready}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst mem_rready", {31'd0, bus.mem_rready}, 32'd0);
    check("rst fwd_busy", {31'd0, bus.fwd_busy}, 32'd0);
    check("rst rf_valid", {31'd0, bus.rf_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    #1;
    check("post rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("late rvalid rready", {31'd0, bus.mem_rready}, 32'd0);
    @(negedge clock);
    idle_inputs();
    check("late rvalid rf_valid", {31'd0, bus.rf_valid}, 32'd0);
    check("late rvalid fwd_busy", {31'd0, bus.fwd_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
